// File: rtl/aes_decrypt_top_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_decrypt_top_pkg
// Brief    : Shared widths, FSM encoding and GF(2^8) helpers for AES-128
//            decryption (S-box and inverse S-box computed algebraically).
// Revision : 1.0
// ============================================================================
package aes_decrypt_top_pkg;

  localparam int KEY_S = 128;
  localparam int BLK_S = 128;
  localparam int NK    = 4;
  localparam int NR    = 10;

  // InvMixColumns multiplier constants
  localparam logic [7:0] INV_MC_0E = 8'h0e;
  localparam logic [7:0] INV_MC_0B = 8'h0b;
  localparam logic [7:0] INV_MC_0D = 8'h0d;
  localparam logic [7:0] INV_MC_09 = 8'h09;

  typedef enum logic [2:0] {
    DEC_IDLE   = 3'd0,
    DEC_KEYEXP = 3'd1,
    DEC_KEY10  = 3'd2,
    DEC_ROUND  = 3'd3,
    DEC_FINAL  = 3'd4
  } dec_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] v;
    v = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    return gf_inv(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inv_round.sv
`default_nettype none
// ============================================================================
// Module   : inv_round
// Brief    : One combinational inverse round: InvShiftRows, InvSubBytes,
//            AddRoundKey, then InvMixColumns unless 'last'.
// Revision : 1.0
// ============================================================================
module inv_round
  import aes_decrypt_top_pkg::*;
(
  input  logic [0:BLK_S-1] state,
  input  logic [0:KEY_S-1] round_key,
  input  logic             last,
  output logic [0:BLK_S-1] result
);

  logic [15:0][7:0] ab;
  logic [15:0][7:0] mc;

  // Byte i sits at row i%4, column i/4; InvShiftRows rotates row r right by r
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int ROW = i % 4;
    localparam int COL = i / 4;
    localparam int SRC = ROW + 4 * ((COL + 4 - ROW) % 4);
    assign ab[i] = inv_sbox(state[8*SRC +: 8]) ^ round_key[8*i +: 8];
    assign result[8*i +: 8] = last ? ab[i] : mc[i];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ab[4*c];
    assign a1 = ab[4*c+1];
    assign a2 = ab[4*c+2];
    assign a3 = ab[4*c+3];
    assign mc[4*c]   = gf_mul(INV_MC_0E, a0) ^ gf_mul(INV_MC_0B, a1) ^ gf_mul(INV_MC_0D, a2) ^ gf_mul(INV_MC_09, a3);
    assign mc[4*c+1] = gf_mul(INV_MC_09, a0) ^ gf_mul(INV_MC_0E, a1) ^ gf_mul(INV_MC_0B, a2) ^ gf_mul(INV_MC_0D, a3);
    assign mc[4*c+2] = gf_mul(INV_MC_0D, a0) ^ gf_mul(INV_MC_09, a1) ^ gf_mul(INV_MC_0E, a2) ^ gf_mul(INV_MC_0B, a3);
    assign mc[4*c+3] = gf_mul(INV_MC_0B, a0) ^ gf_mul(INV_MC_0D, a1) ^ gf_mul(INV_MC_09, a2) ^ gf_mul(INV_MC_0E, a3);
  end

endmodule
`default_nettype wire

// File: rtl/key_sram.sv
`default_nettype none
// ============================================================================
// Module   : key_sram
// Brief    : 11-entry round-key store, synchronous write, 1-cycle read.
// Revision : 1.0
// ============================================================================
module key_sram
  import aes_decrypt_top_pkg::*;
(
  input  logic             clk,
  input  logic             w_e,
  input  logic             r_e,
  input  logic [3:0]       addr,
  input  logic [0:KEY_S-1] w_data,
  output logic [0:KEY_S-1] r_data
);

  logic [0:KEY_S-1] mem [0:NR];

  // Storage is deliberately not reset; key_valid in the top guards reads
  always_ff @(posedge clk) begin
    if (w_e) mem[addr] <= w_data;
    if (r_e) r_data <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/round_key.sv
`default_nettype none
// ============================================================================
// Module   : round_key
// Brief    : Iterative AES-128 key expansion; emits one round key per cycle
//            with a write strobe, then pulses en_o after round key 10.
// Revision : 1.0
// ============================================================================
module round_key
  import aes_decrypt_top_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [0:KEY_S-1] key,
  output logic             w_e,
  output logic [3:0]       key_round_no,
  output logic [0:KEY_S-1] round_key,
  output logic             en_o
);

  logic             active;
  logic [3:0]       rnd;
  logic [7:0]       rcon;
  logic [0:KEY_S-1] cur;
  logic [0:KEY_S-1] next_key;
  logic [31:0]      wd [NK];
  logic [31:0]      nw [NK];
  logic [31:0]      tmp;

  // Next round key from the current one (RotWord, SubWord, Rcon chain)
  always_comb begin
    for (int i = 0; i < NK; i++) wd[i] = cur[32*i +: 32];
    tmp = {wd[NK-1][23:0], wd[NK-1][31:24]};
    tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])}
          ^ {rcon, 24'h000000};
    nw[0] = wd[0] ^ tmp;
    for (int i = 1; i < NK; i++) nw[i] = wd[i] ^ nw[i-1];
    for (int i = 0; i < NK; i++) next_key[32*i +: 32] = nw[i];
  end

  // Expansion sequencer: round keys 0..10 presented on consecutive cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      rnd    <= 4'd0;
      rcon   <= 8'h01;
      cur    <= '0;
      en_o   <= 1'b0;
    end else begin
      en_o <= 1'b0;
      if (!active && en) begin
        active <= 1'b1;
        rnd    <= 4'd0;
        rcon   <= 8'h01;
        cur    <= key;
      end else if (active) begin
        cur  <= next_key;
        rcon <= xtime(rcon);
        rnd  <= rnd + 4'd1;
        if (rnd == 4'(NR)) begin
          active <= 1'b0;
          en_o   <= 1'b1;
        end
      end
    end
  end

  assign w_e          = active;
  assign key_round_no = rnd;
  assign round_key    = cur;

endmodule
`default_nettype wire

// File: rtl/aes_decrypt_top.sv
`default_nettype none
// ============================================================================
// Module   : aes_decrypt_top
// Brief    : AES-128 iterative decryptor, one round per clock. Optionally
//            expands a new key into key_sram, then reads round keys 10..0.
// Revision : 1.0
// ============================================================================
module aes_decrypt_top
  import aes_decrypt_top_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             aes_key_strobe,
  input  logic [0:KEY_S-1] aes_key,
  input  logic [0:BLK_S-1] aes_ciphertext,
  output logic [0:BLK_S-1] aes_plaintext,
  output logic             en_o,
  output logic             busy,
  output logic             key_valid
);

  dec_state_t       state, next_state;
  logic [3:0]       counter;
  logic [0:BLK_S-1] captured_block;
  logic [0:BLK_S-1] blk_state;
  logic [0:BLK_S-1] round_out;

  logic             rk_en, rk_w_e, rk_done;
  logic [3:0]       rk_addr;
  logic [0:KEY_S-1] rk_data;

  logic             rd_en;
  logic [3:0]       rd_addr;
  logic             sram_w_e;
  logic [3:0]       sram_addr;
  logic [0:KEY_S-1] sram_rdata;

  // round_key samples aes_key itself on the accepting edge
  round_key u_round_key (
    .clk          (clk),
    .reset        (reset),
    .en           (rk_en),
    .key          (aes_key),
    .w_e          (rk_w_e),
    .key_round_no (rk_addr),
    .round_key    (rk_data),
    .en_o         (rk_done)
  );

  assign sram_w_e  = (state == DEC_KEYEXP) && rk_w_e;
  assign sram_addr = sram_w_e ? rk_addr : rd_addr;

  key_sram u_key_sram (
    .clk    (clk),
    .w_e    (sram_w_e),
    .r_e    (rd_en),
    .addr   (sram_addr),
    .w_data (rk_data),
    .r_data (sram_rdata)
  );

  inv_round u_inv_round (
    .state     (blk_state),
    .round_key (sram_rdata),
    .last      (state == DEC_FINAL),
    .result    (round_out)
  );

  assign busy = (state != DEC_IDLE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= DEC_IDLE;
    else        state <= next_state;
  end

  // Next state and key_sram read requests; reads run one state ahead of use
  always_comb begin
    next_state = state;
    rk_en      = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = 4'd0;
    case (state)
      DEC_IDLE: begin
        if (en && aes_key_strobe) begin
          rk_en      = 1'b1;
          next_state = DEC_KEYEXP;
        end else if (en && key_valid) begin
          rd_en      = 1'b1;
          rd_addr    = 4'(NR);
          next_state = DEC_KEY10;
        end
      end
      DEC_KEYEXP: begin
        if (rk_done) begin
          rd_en      = 1'b1;
          rd_addr    = 4'(NR);
          next_state = DEC_KEY10;
        end
      end
      DEC_KEY10: begin
        rd_en      = 1'b1;
        rd_addr    = 4'(NR - 1);
        next_state = DEC_ROUND;
      end
      DEC_ROUND: begin
        rd_en   = 1'b1;
        rd_addr = counter - 4'd1;
        if (counter == 4'd1) next_state = DEC_FINAL;
      end
      DEC_FINAL: next_state = DEC_IDLE;
      default:   next_state = DEC_IDLE;
    endcase
  end

  // Datapath: block capture, round iteration, result and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aes_plaintext  <= '0;
      en_o           <= 1'b0;
      key_valid      <= 1'b0;
      counter        <= 4'd0;
      captured_block <= '0;
      blk_state      <= '0;
    end else begin
      en_o <= 1'b0;
      case (state)
        DEC_IDLE: begin
          if (en && (aes_key_strobe || key_valid)) captured_block <= aes_ciphertext;
          // A new expansion overwrites the schedule, so it is invalid until done
          if (en && aes_key_strobe) key_valid <= 1'b0;
        end
        DEC_KEYEXP: begin
          if (rk_done) key_valid <= 1'b1;
        end
        DEC_KEY10: begin
          blk_state <= captured_block ^ sram_rdata;
          counter   <= 4'(NR - 1);
        end
        DEC_ROUND: begin
          blk_state <= round_out;
          counter   <= counter - 4'd1;
        end
        DEC_FINAL: begin
          aes_plaintext <= round_out;
          en_o          <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_decrypt_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_decrypt_top
// Brief    : Scoreboard bench for aes_decrypt_top with FIPS-197 vectors and
//            an independent forward-cipher model for random blocks.
// Revision : 1.0
// ============================================================================
module tb_aes_decrypt_top;

  localparam logic [0:127] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         aes_key_strobe = 1'b0;
  logic [0:127] aes_key = '0;
  logic [0:127] aes_ciphertext = '0;
  logic [0:127] aes_plaintext;
  logic         en_o, busy, key_valid;

  int tests = 0, fails = 0, cyc = 0, en_o_count = 0, pushes = 0;

  typedef struct {
    logic [0:127] pt;
    int           lat;
    int           acc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  aes_decrypt_top dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .aes_key_strobe (aes_key_strobe),
    .aes_key        (aes_key),
    .aes_ciphertext (aes_ciphertext),
    .aes_plaintext  (aes_plaintext),
    .en_o           (en_o),
    .busy           (busy),
    .key_valid      (key_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // ---------------- forward-cipher reference model ----------------
  function automatic logic [7:0] m_sb(input logic [7:0] x);
    return SBOX[8*x +: 8];
  endfunction

  function automatic logic [7:0] m_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:127] m_enc(input logic [0:127] pt, input logic [0:127] key);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [0:127] res;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {m_sb(tmp[31:24]), m_sb(tmp[23:16]), m_sb(tmp[15:8]), m_sb(tmp[7:0])} ^ {rc, 24'h0};
        rc  = m_xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[q+4*c] = m_sb(s[q + 4*((c+q)%4)]);
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = m_xt(a0) ^ m_xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m_xt(a1) ^ m_xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m_xt(a2) ^ m_xt(a3) ^ a3;
          s[4*c+3] = m_xt(a0) ^ a0 ^ a1 ^ a2 ^ m_xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
    return res;
  endfunction

  // ---------------- monitor: pops the scoreboard on every en_o ----------------
  always @(negedge clk) begin
    if (reset && en_o) begin
      en_o_count++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_en_o: got pulse with %h, required no pulse", aes_plaintext);
      end else begin
        mon_e = exp_q.pop_front();
        check("plaintext", aes_plaintext, mon_e.pt);
        if (mon_e.lat != 0) check("latency", 128'(cyc - mon_e.acc), 128'(mon_e.lat));
      end
    end
  end

  // Called at a negedge; en is sampled on the following posedge (edge 0)
  task automatic issue(input logic s, input logic [0:127] k, input logic [0:127] c,
                       input logic push, input logic [0:127] p, input int lat);
    en = 1'b1; aes_key_strobe = s; aes_key = k; aes_ciphertext = c;
    @(negedge clk);
    en = 1'b0; aes_key_strobe = 1'b0;
    if (push) begin
      exp_q.push_back('{pt: p, lat: lat, acc: cyc});
      pushes++;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic         busy_seen;
    logic [0:127] p, c;

    repeat (3) @(negedge clk);
    check("rst_plaintext", aes_plaintext, 128'h0);
    check("rst_en_o", en_o, 0);
    check("rst_busy", busy, 0);
    check("rst_key_valid", key_valid, 0);
    reset = 1'b1;
    @(negedge clk);

    // No key loaded: request must be dropped
    issue(1'b0, KEY_B, CT_B, 1'b0, '0, 0);
    busy_seen = 1'b0;
    repeat (50) begin
      if (busy) busy_seen = 1'b1;
      @(negedge clk);
    end
    check("nokey_busy", busy_seen, 0);
    check("nokey_plaintext", aes_plaintext, 128'h0);
    check("nokey_key_valid", key_valid, 0);

    // FIPS-197 C.1 with key expansion
    issue(1'b1, KEY_C1, CT_C1, 1'b1, PT_C1, 0);
    wait_idle("c1");
    check("c1_key_valid", key_valid, 1);

    // Load the Appendix B key, then reuse it without strobe
    issue(1'b1, KEY_B, CT_B, 1'b1, PT_B, 0);
    wait_idle("b_strobe");
    issue(1'b0, KEY_C1, CT_B, 1'b1, PT_B, 11);
    wait_idle("b_reuse");

    // Busy rejection: extra en at edges 3 and 11 with a different block
    issue(1'b0, '0, CT_B, 1'b1, PT_B, 11);
    for (int e = 1; e <= 11; e++) begin
      en = (e == 3 || e == 11);
      aes_ciphertext = CT_C1;
      @(negedge clk);
    end
    en = 1'b0;
    check("busy_after_edge11", busy, 0);
    @(negedge clk);
    check("busy_no_requeue", busy, 0);

    // Reset during a decryption at edge 5
    issue(1'b0, '0, CT_B, 1'b0, '0, 0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_key_valid", key_valid, 0);
    check("midrst_plaintext", aes_plaintext, 128'h0);
    check("midrst_busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);
    issue(1'b1, KEY_C1, CT_C1, 1'b1, PT_C1, 0);
    wait_idle("c1_after_rst");
    check("c1_after_rst_key_valid", key_valid, 1);

    // Back-to-back random blocks under KEY_C1
    for (int i = 0; i < 100; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      c = m_enc(p, KEY_C1);
      issue(1'b0, '0, c, 1'b1, p, 11);
      wait_idle("b2b");
    end

    repeat (30) @(negedge clk);
    check("en_o_count", 128'(en_o_count), 128'(pushes));
    check("queue_drained", 128'(exp_q.size()), 128'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_decrypt_top.md
Name: aes_decrypt_top

Overview:
AES-128 decryption top, the inverse counterpart of the encryption top. It expands a key on request using the existing round_key generator and stores the 11 round keys in the existing key_sram. It then runs the inverse cipher iteratively, one round per clock, reading round keys in descending order (10 down to 0). It sits beside the encryption top and presents the same en / en_o pulse interface to the AXI-stream wrapper.

Parameters:
none; all widths come from aes.vh (`KEY_S` = 128, `BLK_S` = 128, `Nk`, plus the new `Nr` = 10).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  one-cycle request pulse; sampled only in IDLE
aes_key_strobe  in  1  qualifies en: expand aes_key before decrypting
aes_key  in  `KEY_S`  cipher key, bit 0 = MSB of byte 0
aes_ciphertext  in  `BLK_S`  input block, sampled with en
aes_plaintext  out  `BLK_S`  result; held stable until the next result
en_o  out  1  one-cycle pulse: aes_plaintext valid
busy  out  1  high in every state except IDLE
key_valid  out  1  high once a full key schedule is stored

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; aes_plaintext = 0; en_o = 0; busy = 0; key_valid = 0; round counter = 0.
  - SRAM contents are not cleared; key_valid = 0 forces a new strobe before any decryption.
- FSM states: IDLE, KEYEXP, KEY10, ROUND, FINAL.
- IDLE:
  - en & aes_key_strobe -> capture aes_ciphertext and aes_key; pulse round_key en; go to KEYEXP.
  - en & !aes_key_strobe & key_valid -> capture aes_ciphertext; drive key_sram addr = 10, r_e = 1; go to KEY10.
  - en & !aes_key_strobe & !key_valid -> request dropped; no en_o; stay IDLE.
- KEYEXP:
  - key_sram addr/w_e are driven by round_key (addr = key_round_no while w_e).
  - On round_key en_o: set key_valid = 1; issue read addr 10; go to KEY10.
- KEY10: state_reg = captured block ^ key10; issue read addr 9; counter = 9; go to ROUND.
- ROUND, each cycle:
  - state_reg = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), key[counter])).
  - Issue read addr counter-1, then decrement the counter.
  - When counter == 1 the read address issued is 0 -> go to FINAL.
- FINAL:
  - aes_plaintext = AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), key0); en_o = 1 for exactly one cycle.
  - Go to IDLE.
- key_sram read latency is 1 cycle: the address is always issued one state ahead of its use.
- Latency without strobe: the en-sampling edge is edge 0; aes_plaintext and en_o update on edge 11; next request accepted from edge 12.
- Latency with strobe: (round_key latency) + 11 edges.
- en while busy: ignored, with no queuing and no effect on the in-flight operation. This includes en arriving in the same cycle as FINAL.
- aes_key / aes_ciphertext changing while busy: no effect (both captured at acceptance).
- Reset asserted mid-operation: immediate return to IDLE, en_o never pulses, key_valid = 0 even if expansion had completed.
- Byte/bit order: `[0:N-1]` big-endian. State byte i = bits 8i..8i+7, column-major as in FIPS-197.

Decomposition:
- aes.vh gains:
  - `Nr` (10).
  - State encodings `DEC_IDLE` … `DEC_FINAL`.
  - The InvMixColumns multiplier constants (0e, 0b, 0d, 09).
- Sub-module inv_round (combinational):
  - Inputs: state, round key, `last` flag.
  - Applies InvShiftRows, InvSubBytes (inverse S-box table), AddRoundKey, then InvMixColumns unless `last`.
  - Used in both ROUND and FINAL.
- round_key and key_sram are instantiated unchanged.

Test Plan:
- FIPS-197 C.1: en + strobe, key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> one en_o, aes_plaintext 00112233445566778899aabbccddeeff, key_valid = 1.
- Key reuse: then en without strobe, key 2b7e151628aed2a6abf7158809cf4f3c loaded previously via strobe, ct 3925841d02dc09fbdc118597196a0b32 -> aes_plaintext 3243f6a8885a308d313198a2e0370734, en_o exactly 11 edges after acceptance.
- No key: after reset, en without strobe -> no en_o for 50 cycles, busy stays 0, aes_plaintext = 0.
- Busy rejection: second en with different ct at edges 3 and 11 of a decryption -> single en_o carrying the first block's plaintext; busy falls after edge 11.
- Reset mid-run: reset low at edge 5 of a decryption -> no en_o, key_valid = 0, aes_plaintext = 0; a subsequent strobed C.1 request decrypts correctly.
- Back-to-back: 100 random blocks under one key, each en issued the cycle after busy falls -> every output matches the reference model, one en_o per request.
